// File: rtl/rsa_ctrl_pkg.sv
// Shared types and address helper for the RSA run controller.
// State encoding is fixed at 3 bits so it can be probed on a debug bus.
package rsa_ctrl_pkg;

  typedef enum logic [2:0] {
    stIdle,
    stLoad,
    stStart,
    stRun,
    stDrainAddr,
    stDrainOut,
    stDone,
    stErr
  } ctrl_state_t;

  localparam int WORD_BYTES = 4;

  // Word index to byte address; wraps modulo 2^32 by construction.
  function automatic logic [31:0] addr_of(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx * 32'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/rsa_run_controller_if.sv
// Host-side operand write channel and result byte stream.
// master = host, slave = run controller.
interface rsa_run_controller_if;
  logic        host_go;
  logic        host_wr_valid;
  logic [31:0] host_wr_data;
  logic        host_wr_ready;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_ready;

  modport master (
    output host_go, host_wr_valid, host_wr_data, res_ready,
    input  host_wr_ready, res_valid, res_data
  );

  modport slave (
    input  host_go, host_wr_valid, host_wr_data, res_ready,
    output host_wr_ready, res_valid, res_data
  );
endinterface

// File: rtl/rsa_run_controller_mem_port_mux.sv
// Data-memory port selector: the CPU owns the port only while running,
// otherwise the controller's signals go through untouched.
module mem_port_mux (
  input  logic        ownCpu,
  input  logic        cpuWe,
  input  logic [31:0] cpuAdr,
  input  logic [31:0] cpuWd,
  input  logic        ctrlWe,
  input  logic [31:0] ctrlAdr,
  input  logic [31:0] ctrlWd,
  output logic        memWe,
  output logic [31:0] memAdr,
  output logic [31:0] memWd
);
  assign memWe  = ownCpu ? cpuWe  : ctrlWe;
  assign memAdr = ownCpu ? cpuAdr : ctrlAdr;
  assign memWd  = ownCpu ? cpuWd  : ctrlWd;
endmodule

// File: rtl/rsa_run_controller.sv
// Run sequencer: loads operands, starts the CPU, watches for EndFlag or a
// watchdog expiry, then streams the low byte of each result word to the host.
module rsa_run_controller
  import rsa_ctrl_pkg::*;
#(
  parameter logic [31:0] LOAD_BASE      = 32'h0000_0000,
  parameter int          LOAD_WORDS     = 4,
  parameter logic [31:0] RESULT_BASE    = 32'h0000_0040,
  parameter int          RESULT_WORDS   = 4,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  rsa_run_controller_if.slave  host,
  output logic                 cpu_reset,
  output logic                 cpu_start,
  input  logic                 cpu_MemWrite,
  input  logic [31:0]          cpu_DataAdr,
  input  logic [31:0]          cpu_WriteData,
  input  logic                 cpu_EndFlag,
  output logic                 mem_WriteEnable,
  output logic [31:0]          mem_DataAddress,
  output logic [31:0]          mem_WriteData,
  input  logic [31:0]          mem_ReadData,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout
);

  localparam int MaxWords = (LOAD_WORDS > RESULT_WORDS) ? LOAD_WORDS : RESULT_WORDS;
  localparam int IdxW     = $clog2(MaxWords + 1);
  localparam int CntW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IdxW-1:0] LastLoad   = IdxW'(LOAD_WORDS - 1);
  localparam logic [IdxW-1:0] LastResult = IdxW'(RESULT_WORDS - 1);
  localparam logic [CntW-1:0] LastCycle  = CntW'(TIMEOUT_CYCLES - 1);

  ctrl_state_t     stateReg, stateNext;
  logic [IdxW-1:0] idxReg, idxNext;
  logic [CntW-1:0] cntReg, cntNext;
  logic [7:0]      resDataReg, resDataNext;
  logic            loadXfer, ownCpu, ctrlWe;
  logic [31:0]     ctrlAdr, ctrlWd;
  logic            unusedReadBits;

  assign unusedReadBits = ^mem_ReadData[31:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg   <= stIdle;
      idxReg     <= '0;
      cntReg     <= '0;
      resDataReg <= '0;
    end else begin
      stateReg   <= stateNext;
      idxReg     <= idxNext;
      cntReg     <= cntNext;
      resDataReg <= resDataNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    idxNext     = idxReg;
    cntNext     = cntReg;
    resDataNext = resDataReg;
    case (stateReg)
      stIdle, stDone, stErr: begin
        if (host.host_go) begin
          stateNext = stLoad;
          idxNext   = '0;
          cntNext   = '0;
        end
      end
      stLoad: begin
        if (loadXfer) begin
          if (idxReg == LastLoad) begin
            stateNext = stStart;
            idxNext   = '0;
          end else begin
            idxNext = idxReg + 1'b1;
          end
        end
      end
      stStart: stateNext = stRun;
      stRun: begin
        cntNext = cntReg + 1'b1;
        // EndFlag takes priority over a watchdog expiry in the same cycle.
        if (cpu_EndFlag) begin
          stateNext = stDrainAddr;
          idxNext   = '0;
        end else if (cntReg == LastCycle) begin
          stateNext = stErr;
        end
      end
      stDrainAddr: begin
        resDataNext = mem_ReadData[7:0];
        stateNext   = stDrainOut;
      end
      stDrainOut: begin
        if (host.res_ready) begin
          if (idxReg == LastResult) begin
            stateNext = stDone;
          end else begin
            idxNext   = idxReg + 1'b1;
            stateNext = stDrainAddr;
          end
        end
      end
      default: stateNext = stIdle;
    endcase
  end

  always_comb begin
    ctrlAdr = '0;
    case (stateReg)
      stLoad:                  ctrlAdr = addr_of(LOAD_BASE, 32'(idxReg));
      stDrainAddr, stDrainOut: ctrlAdr = addr_of(RESULT_BASE, 32'(idxReg));
      default:                 ctrlAdr = '0;
    endcase
  end

  assign loadXfer           = (stateReg == stLoad) && host.host_wr_valid;
  assign host.host_wr_ready = (stateReg == stLoad);
  assign host.res_valid     = (stateReg == stDrainOut);
  assign host.res_data      = resDataReg;

  assign cpu_start = (stateReg == stStart);
  assign cpu_reset = !((stateReg == stStart) || (stateReg == stRun));
  assign busy      = !((stateReg == stIdle) || (stateReg == stDone) || (stateReg == stErr));
  assign done      = (stateReg == stDone);
  assign timeout   = (stateReg == stErr);

  assign ownCpu = (stateReg == stRun);
  assign ctrlWe = loadXfer;
  assign ctrlWd = (stateReg == stLoad) ? host.host_wr_data : 32'h0;

  mem_port_mux memMux (
    .ownCpu (ownCpu),
    .cpuWe  (cpu_MemWrite),
    .cpuAdr (cpu_DataAdr),
    .cpuWd  (cpu_WriteData),
    .ctrlWe (ctrlWe),
    .ctrlAdr(ctrlAdr),
    .ctrlWd (ctrlWd),
    .memWe  (mem_WriteEnable),
    .memAdr (mem_DataAddress),
    .memWd  (mem_WriteData)
  );

endmodule

// File: tb/tb_rsa_run_controller.sv
// Directed bench for rsa_run_controller with a 64-word data_mem model;
// results are preloaded at 0x40..0x4C as 0xA1..0xA4.
module tb_rsa_run_controller;

  logic        clk;
  logic        reset;
  logic        cpuReset, cpuStart;
  logic        cpuMemWrite, cpuEndFlag;
  logic [31:0] cpuDataAdr, cpuWriteData;
  logic        memWriteEnable;
  logic [31:0] memDataAddress, memWriteData, memReadData;
  logic        busy, done, timeout;

  rsa_run_controller_if hostIf ();

  rsa_run_controller #(.TIMEOUT_CYCLES(50)) dut (
    .clk            (clk),
    .reset          (reset),
    .host           (hostIf.slave),
    .cpu_reset      (cpuReset),
    .cpu_start      (cpuStart),
    .cpu_MemWrite   (cpuMemWrite),
    .cpu_DataAdr    (cpuDataAdr),
    .cpu_WriteData  (cpuWriteData),
    .cpu_EndFlag    (cpuEndFlag),
    .mem_WriteEnable(memWriteEnable),
    .mem_DataAddress(memDataAddress),
    .mem_WriteData  (memWriteData),
    .mem_ReadData   (memReadData),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  int wrCount = 0;
  int startCount = 0;

  assign memReadData = mem[memDataAddress[7:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i >= 16 && i < 20) ? 32'hA1 + 32'(i - 16) : 32'h0;
    end else if (memWriteEnable) begin
      mem[memDataAddress[7:2]] <= memWriteData;
      wrCount <= wrCount + 1;
    end
    if (cpuStart) startCount <= startCount + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        go;
    logic        wrValid;
    logic [31:0] wrData;
    logic        expReady;
    logic        expWe;
    logic [31:0] expAddr;
    logic        expStart;
    logic        expBusy;
  } vec_t;

  vec_t vecs [15];

  task automatic isolateCpu();
    cpuMemWrite  = 1'b1;
    cpuDataAdr   = 32'hFFFF_FFF0;
    cpuWriteData = 32'hBAD0_BAD0;
  endtask

  task automatic applyVecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      isolateCpu();
      hostIf.host_go       = vecs[i].go;
      hostIf.host_wr_valid = vecs[i].wrValid;
      hostIf.host_wr_data  = vecs[i].wrData;
      #1;
      chk($sformatf("vec%0d.ready", i), hostIf.host_wr_ready, vecs[i].expReady);
      chk($sformatf("vec%0d.we", i), memWriteEnable, vecs[i].expWe);
      chk($sformatf("vec%0d.addr", i), memDataAddress, vecs[i].expAddr);
      chk($sformatf("vec%0d.start", i), cpuStart, vecs[i].expStart);
      chk($sformatf("vec%0d.busy", i), busy, vecs[i].expBusy);
      $display("vec %0d go=%b v=%b d=%h -> rdy=%b we=%b a=%h st=%b busy=%b",
               i, vecs[i].go, vecs[i].wrValid, vecs[i].wrData,
               hostIf.host_wr_ready, memWriteEnable, memDataAddress, cpuStart, busy);
    end
  endtask

  // Loads d0..d0+3 and returns in the START cycle.
  task automatic doLoad(input logic [31:0] d0);
    @(negedge clk);
    hostIf.host_go = 1'b1;
    @(negedge clk);
    hostIf.host_go = 1'b0;
    #1;
    chk("loadClearsTimeout", timeout, 0);
    chk("loadClearsDone", done, 0);
    for (int i = 0; i < 4; i++) begin
      hostIf.host_wr_valid = 1'b1;
      hostIf.host_wr_data  = d0 + 32'(i);
      #1;
      chk($sformatf("loadAddr%0d", i), memDataAddress, 32'(4 * i));
      @(negedge clk);
    end
    hostIf.host_wr_valid = 1'b0;
    #1;
    chk("loadStartPulse", cpuStart, 1);
    $display("load d0=%h done, start=%b", d0, cpuStart);
  endtask

  // RUN cycles 0..endAt; EndFlag is raised on cycle endAt.
  task automatic runPhase(input int endAt, input bit doStore);
    for (int k = 0; k <= endAt; k++) begin
      @(negedge clk);
      cpuMemWrite = 1'b0;
      cpuEndFlag  = (k == endAt);
      if (k == 0) begin
        #1;
        chk("runCpuReset", cpuReset, 0);
        chk("runStartGone", cpuStart, 0);
      end
      if (doStore && k == 3) begin
        cpuMemWrite  = 1'b1;
        cpuDataAdr   = 32'h0000_0080;
        cpuWriteData = 32'h1234_5678;
        #1;
        chk("passWe", memWriteEnable, 1);
        chk("passAddr", memDataAddress, 32'h80);
        chk("passData", memWriteData, 32'h1234_5678);
      end
    end
    $display("run endFlag at cycle %0d", endAt);
  endtask

  task automatic drain(input int holdAt, output int busyCycles);
    logic [7:0] got [4];
    int nGot = 0;
    int hold = 0;
    busyCycles = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      cpuEndFlag = 1'b0;
      isolateCpu();
      #1;
      if (done) break;
      if (busy) busyCycles++;
      if (c == 0) begin
        chk("drainCpuReset", cpuReset, 1);
        chk("drainAddr0", memDataAddress, 32'h40);
        chk("drainNoValidYet", hostIf.res_valid, 0);
      end
      if (c == 1) chk("drainFirstValid", hostIf.res_valid, 1);
      if (c < 3) chk("drainNoCpuWe", memWriteEnable, 0);
      if (hostIf.res_valid) begin
        if (nGot == holdAt && hold < 5) begin
          hostIf.res_ready = 1'b0;
          hold++;
          chk("stallData", hostIf.res_data, 32'(8'(8'hA1 + nGot)));
        end else begin
          hostIf.res_ready = 1'b1;
        end
        if (hostIf.res_ready && nGot < 4) begin
          got[nGot] = hostIf.res_data;
          nGot++;
        end
      end else begin
        hostIf.res_ready = 1'b1;
      end
    end
    chk("drainDone", done, 1);
    chk("drainBytes", nGot, 4);
    if (holdAt >= 0) chk("stallCycles", hold, 5);
    for (int i = 0; i < 4 && i < nGot; i++) chk($sformatf("byte%0d", i), got[i], 32'(8'(8'hA1 + i)));
    $display("drain got %0d bytes, busy cycles %0d", nGot, busyCycles);
  endtask

  initial begin
    #100000;
    $display("FAIL globalTimeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int w0, s0, dc, n;

    vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 32'h4, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 32'h8, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'hC, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h55, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h4, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h66, 1'b1, 1'b1, 32'h4, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h8, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'h77, 1'b1, 1'b1, 32'h8, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'hC, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 32'h88, 1'b1, 1'b1, 32'hC, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b1};

    reset = 1'b1;
    hostIf.host_go = 1'b0;
    hostIf.host_wr_valid = 1'b0;
    hostIf.host_wr_data = 32'h0;
    hostIf.res_ready = 1'b1;
    cpuEndFlag = 1'b0;
    isolateCpu();

    repeat (2) @(negedge clk);
    #1;
    chk("rstReady", hostIf.host_wr_ready, 0);
    chk("rstResValid", hostIf.res_valid, 0);
    chk("rstResData", hostIf.res_data, 0);
    chk("rstCpuReset", cpuReset, 1);
    chk("rstCpuStart", cpuStart, 0);
    chk("rstWe", memWriteEnable, 0);
    chk("rstAddr", memDataAddress, 0);
    chk("rstWdata", memWriteData, 0);
    chk("rstBusy", busy, 0);
    chk("rstDone", done, 0);
    chk("rstTimeout", timeout, 0);
    $display("reset state checked");
    @(negedge clk);
    reset = 1'b0;

    // Basic run
    w0 = wrCount;
    s0 = startCount;
    applyVecs(0, 5);
    runPhase(19, 1'b1);
    drain(-1, dc);
    chk("basicDrainCycles", dc, 8);
    chk("basicWrites", wrCount - w0, 5);
    chk("basicStarts", startCount - s0, 1);
    chk("basicMem0", mem[0], 32'h11);
    chk("basicMem3", mem[3], 32'h44);
    chk("cpuStoreMem", mem[32], 32'h1234_5678);
    chk("basicCpuReset", cpuReset, 1);

    // Load backpressure, then drain backpressure on byte 2
    w0 = wrCount;
    s0 = startCount;
    applyVecs(6, 14);
    @(negedge clk);
    #1;
    chk("bpWrites", wrCount - w0, 4);
    chk("bpStarts", startCount - s0, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("bpMem%0d", i), mem[i], 32'h55 + 32'(i * 17));
    runPhase(4, 1'b0);
    drain(1, dc);

    // Watchdog expiry
    doLoad(32'h100);
    n = 0;
    cpuMemWrite = 1'b0;
    cpuEndFlag = 1'b0;
    while (n <= 100) begin
      @(negedge clk);
      #1;
      if (timeout) break;
      if (n == 49) chk("wdCpuRunning", cpuReset, 0);
      n++;
    end
    chk("wdCycle", n, 50);
    chk("wdTimeout", timeout, 1);
    chk("wdCpuReset", cpuReset, 1);
    chk("wdBusy", busy, 0);
    chk("wdDone", done, 0);
    $display("watchdog fired after %0d RUN cycles", n);

    // EndFlag in the final watchdog cycle wins
    doLoad(32'h200);
    runPhase(49, 1'b0);
    drain(-1, dc);
    chk("lateEndNoTimeout", timeout, 0);

    // Reset in the middle of LOAD
    @(negedge clk);
    hostIf.host_go = 1'b1;
    @(negedge clk);
    hostIf.host_go = 1'b0;
    hostIf.host_wr_valid = 1'b1;
    hostIf.host_wr_data = 32'h99;
    @(negedge clk);
    hostIf.host_wr_data = 32'h98;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midRstReady", hostIf.host_wr_ready, 0);
    chk("midRstBusy", busy, 0);
    chk("midRstWe", memWriteEnable, 0);
    chk("midRstAddr", memDataAddress, 0);
    chk("midRstCpuReset", cpuReset, 1);
    chk("midRstDone", done, 0);
    $display("reset asserted mid-LOAD");
    @(negedge clk);
    reset = 1'b0;
    hostIf.host_wr_valid = 1'b0;
    doLoad(32'h300);
    @(negedge clk);
    #1;
    chk("restartMem0", mem[0], 32'h300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
